morse_char_keyer: RTL and testbench

//  TX-side Morse keyer: converts one character index (0-25 = A-Z, 31 = word space)

---
 rtl/morse_char_keyer.sv | 214 +++++++++++++++++++++
 tb/tb_morse_char_keyer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_keyer.sv
// Purpose: TX Morse keyer; turns a latched character index into timed key-down/key-up
//          intervals, a done pulse and a square-wave buzzer drive.
// Latency: key goes high in the cycle after the accepting edge. Busy lasts
//          (marks + symbol gaps + 3) units, or 7 units for a space. A one-cycle done follows.
// Backpressure: i_start is honoured only in IDLE. Starts while busy or done are dropped and not queued.
// Ports: iCLK/iRST_N clock and async active-low reset; i_start/i_char_idx request;
//        o_busy, o_done, o_key key/status outputs; oBuzzer tone while keyed.
module morse_char_keyer #(
  parameter int UNIT_CYCLES = 2_500_000,
  parameter int TONE_HALF   = 25_000,
  parameter int CNT_W       = 22
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       i_start,
  input  logic [4:0] i_char_idx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_key,
  output logic       oBuzzer
);

  localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [CNT_W-1:0]  UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [4:0]        IDX_SPACE = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SYM_GAP,
    S_CHAR_GAP,
    S_WORD_GAP,
    S_DONE
  } state_t;

  // Returns {len[2:0], pattern[3:0]}. The first symbol is pattern[len-1], and 1 means dash.
  // A length of 0 marks an index with no Morse code.
  function automatic logic [6:0] morse_lut(input logic [4:0] idx);
    logic [6:0] r;
    case (idx)
      5'd0:  r = {3'd2, 4'b0001}; // A .-
      5'd1:  r = {3'd4, 4'b1000}; // B -...
      5'd2:  r = {3'd4, 4'b1010}; // C -.-.
      5'd3:  r = {3'd3, 4'b0100}; // D -..
      5'd4:  r = {3'd1, 4'b0000}; // E .
      5'd5:  r = {3'd4, 4'b0010}; // F ..-.
      5'd6:  r = {3'd3, 4'b0110}; // G --.
      5'd7:  r = {3'd4, 4'b0000}; // H ....
      5'd8:  r = {3'd2, 4'b0000}; // I ..
      5'd9:  r = {3'd4, 4'b0111}; // J .---
      5'd10: r = {3'd3, 4'b0101}; // K -.-
      5'd11: r = {3'd4, 4'b0100}; // L .-..
      5'd12: r = {3'd2, 4'b0011}; // M --
      5'd13: r = {3'd2, 4'b0010}; // N -.
      5'd14: r = {3'd3, 4'b0111}; // O ---
      5'd15: r = {3'd4, 4'b0110}; // P .--.
      5'd16: r = {3'd4, 4'b1101}; // Q --.-
      5'd17: r = {3'd3, 4'b0010}; // R .-.
      5'd18: r = {3'd3, 4'b0000}; // S ...
      5'd19: r = {3'd1, 4'b0001}; // T -
      5'd20: r = {3'd3, 4'b0001}; // U ..-
      5'd21: r = {3'd4, 4'b0001}; // V ...-
      5'd22: r = {3'd3, 4'b0011}; // W .--
      5'd23: r = {3'd4, 4'b1001}; // X -..-
      5'd24: r = {3'd4, 4'b1011}; // Y -.--
      5'd25: r = {3'd4, 4'b1100}; // Z --..
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         pat_q, pat_d;
  logic [1:0]         ptr_q, ptr_d;      // index of the symbol being keyed
  logic [2:0]         units_q, units_d;  // remaining whole units after the current one
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TONE_W-1:0]  tone_cnt_q, tone_cnt_d;
  logic               buzz_q, buzz_d;
  logic               inv_q, inv_d;      // done pulse for a rejected (invalid) index

  logic [6:0] lut;
  logic [2:0] lut_len;
  logic [3:0] lut_pat;
  logic [1:0] first_ptr;
  logic [1:0] ptr_m1;
  logic       unit_wrap;
  logic       phase_end;
  logic       timed;

  always_comb begin
    lut       = morse_lut(i_char_idx);
    lut_len   = lut[6:4];
    lut_pat   = lut[3:0];
    first_ptr = lut_len[1:0] - 2'd1;   // a length of 4 wraps to 3 as intended
    ptr_m1    = ptr_q - 2'd1;
    unit_wrap = (cnt_q == UNIT_LAST);
    phase_end = unit_wrap && (units_q == 3'd0);
    timed     = (state_q == S_MARK) || (state_q == S_SYM_GAP) ||
                (state_q == S_CHAR_GAP) || (state_q == S_WORD_GAP);

    state_d    = state_q;
    pat_d      = pat_q;
    ptr_d      = ptr_q;
    units_d    = units_q;
    cnt_d      = cnt_q;
    inv_d      = 1'b0;

    // The unit counter is shared by all timed phases. When a phase ends, the counter
    // has already wrapped to 0, so the next phase starts on a clean unit boundary.
    if (timed) begin
      if (unit_wrap) begin
        cnt_d = '0;
        if (units_q != 3'd0) begin
          units_d = units_q - 3'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_char_idx == IDX_SPACE) begin
            state_d = S_WORD_GAP;
            units_d = 3'd6;
            cnt_d   = '0;
          end else if (lut_len != 3'd0) begin
            state_d = S_MARK;
            pat_d   = lut_pat;
            ptr_d   = first_ptr;
            units_d = lut_pat[first_ptr] ? 3'd2 : 3'd0;
            cnt_d   = '0;
          end else begin
            inv_d   = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (phase_end) begin
          if (ptr_q == 2'd0) begin
            state_d = S_CHAR_GAP;
            units_d = 3'd2;
          end else begin
            state_d = S_SYM_GAP;
            units_d = 3'd0;
          end
        end
      end
      S_SYM_GAP: begin
        if (phase_end) begin
          state_d = S_MARK;
          ptr_d   = ptr_m1;
          units_d = pat_q[ptr_m1] ? 3'd2 : 3'd0;
        end
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (phase_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The tone runs only while the key stays down. The counter and the buzzer clear
    // on the edge where the key goes up, so each mark starts from a low buzzer.
    tone_cnt_d = '0;
    buzz_d     = 1'b0;
    if ((state_q == S_MARK) && (state_d == S_MARK)) begin
      if (tone_cnt_q == TONE_LAST) begin
        tone_cnt_d = '0;
        buzz_d     = ~buzz_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
        buzz_d     = buzz_q;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      ptr_q      <= '0;
      units_q    <= '0;
      cnt_q      <= '0;
      tone_cnt_q <= '0;
      buzz_q     <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      ptr_q      <= ptr_d;
      units_q    <= units_d;
      cnt_q      <= cnt_d;
      tone_cnt_q <= tone_cnt_d;
      buzz_q     <= buzz_d;
      inv_q      <= inv_d;
    end
  end

  // The outputs decode the registered state only, so an asynchronous reset clears them at once.
  assign o_key   = (state_q == S_MARK);
  assign o_busy  = timed;
  assign o_done  = (state_q == S_DONE) || inv_q;
  assign oBuzzer = buzz_q;

endmodule

// File: tb/tb_morse_char_keyer.sv
// Purpose: self-checking bench for morse_char_keyer using a per-cycle expected-output queue
// Latency: expected entries start in the cycle after the accepting edge
// Backpressure: the model accepts a start only when its queue is empty and no char-done just ended
module tb_morse_char_keyer;

  localparam int U  = 10;
  localparam int TH = 2;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       i_start;
  logic [4:0] i_char_idx;
  logic       o_busy, o_done, o_key, oBuzzer;

  morse_char_keyer #(.UNIT_CYCLES(U), .TONE_HALF(TH), .CNT_W(8)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .i_start(i_start), .i_char_idx(i_char_idx),
    .o_busy(o_busy), .o_done(o_done), .o_key(o_key), .oBuzzer(oBuzzer)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic busy;
    logic done;
    logic key;
    logic buzz;
    logic hold;   // a character-done cycle: the next edge is still not IDLE
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic last_hold = 1'b0;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  string codes[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expands one character into its per-cycle outputs, following the Morse timing rules.
  function automatic void push_char(input logic [4:0] idx);
    exp_t e;
    if (idx <= 5'd25) begin
      string code = codes[idx];
      for (int i = 0; i < code.len(); i++) begin
        byte c = code[i];
        int  m = (c == "-") ? 3 : 1;
        int  g = (i == code.len() - 1) ? 3 : 1;
        for (int t = 0; t < m * U; t++) begin
          e = '{busy: 1'b1, done: 1'b0, key: 1'b1, buzz: logic'((t / TH) % 2), hold: 1'b0};
          q.push_back(e);
        end
        for (int t = 0; t < g * U; t++) begin
          e = '{busy: 1'b1, done: 1'b0, key: 1'b0, buzz: 1'b0, hold: 1'b0};
          q.push_back(e);
        end
      end
      e = '{busy: 1'b0, done: 1'b1, key: 1'b0, buzz: 1'b0, hold: 1'b1};
      q.push_back(e);
    end else if (idx == 5'd31) begin
      for (int t = 0; t < 7 * U; t++) begin
        e = '{busy: 1'b1, done: 1'b0, key: 1'b0, buzz: 1'b0, hold: 1'b0};
        q.push_back(e);
      end
      e = '{busy: 1'b0, done: 1'b1, key: 1'b0, buzz: 1'b0, hold: 1'b1};
      q.push_back(e);
    end else begin
      e = '{busy: 1'b0, done: 1'b1, key: 1'b0, buzz: 1'b0, hold: 1'b0};
      q.push_back(e);
    end
  endfunction

  function automatic int key_cycles();
    int n = 0;
    foreach (q[i]) n += int'(q[i].key);
    return n;
  endfunction

  always @(negedge iCLK) begin
    if (chk_en) begin
      cur = (q.size() > 0) ? q.pop_front() : '0;
      last_hold <= cur.hold;
      total++;
      if ({o_busy, o_done, o_key, oBuzzer} !== {cur.busy, cur.done, cur.key, cur.buzz}) begin
        bad++;
        $display("FAIL cycle_outputs: got busy/done/key/buzz=%b%b%b%b expected %b%b%b%b at %0t",
                 o_busy, o_done, o_key, oBuzzer, cur.busy, cur.done, cur.key, cur.buzz, $time);
      end
    end
  end

  task automatic send(input logic [4:0] idx);
    @(posedge iCLK);
    #1;
    i_start    = 1'b1;
    i_char_idx = idx;
    @(posedge iCLK);
    if (q.size() == 0 && !last_hold) push_char(idx);
    #1;
    i_start    = 1'b0;
    i_char_idx = 5'($urandom);   // the DUT latches at accept, so the index bus may change freely
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    if (q.size() != 0) begin
      chk("wait_idle_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge iCLK);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, int'({o_busy, o_done, o_key, oBuzzer}), 0);
  endtask

  initial begin
    logic [4:0] r;
    iRST_N     = 1'b0;
    i_start    = 1'b0;
    i_char_idx = 5'd0;
    #23;
    chk_outputs_zero("reset_state");
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1 chk_en = 1'b1;

    // E: the model must yield a 10-cycle mark, 40 busy cycles, done, and buzzer 0,0,1,1,0,0.
    send(5'd4);
    chk("model_E_len", q.size(), 41);
    chk("model_E_key", key_cycles(), 10);
    chk("model_E_buzz", int'({q[0].buzz, q[1].buzz, q[2].buzz, q[3].buzz, q[4].buzz, q[5].buzz}),
        int'(6'b001100));
    wait_idle(200);

    send(5'd7);
    chk("model_H_len", q.size(), 101);
    chk("model_H_key", key_cycles(), 40);
    wait_idle(200);

    send(5'd11);
    chk("model_L_len", q.size(), 121);
    wait_idle(200);
    send(5'd14);
    chk("model_O_len", q.size(), 141);
    chk("model_O_key", key_cycles(), 90);
    wait_idle(200);

    send(5'd31);
    chk("model_space_len", q.size(), 71);
    chk("model_space_key", key_cycles(), 0);
    wait_idle(200);

    send(5'd27);
    chk("model_invalid_len", q.size(), 1);
    wait_idle(20);

    // Q with a stray start five cycles in; the stray request must be dropped.
    send(5'd16);
    repeat (3) @(posedge iCLK);
    send(5'd4);
    wait_idle(300);

    // Reset in the middle of O's first dash.
    send(5'd14);
    repeat (15) @(negedge iCLK);
    chk("pre_reset_key", int'(o_key), 1);
    chk_en = 1'b0;
    #2 iRST_N = 1'b0;
    #1 chk_outputs_zero("reset_mid_dash");
    q.delete();
    last_hold = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk_outputs_zero("reset_held");
    iRST_N = 1'b1;
    #1 chk_en = 1'b1;
    send(5'd0);
    chk("model_A_len", q.size(), 81);
    wait_idle(200);

    // Random traffic: valid letters, spaces and invalid indices, with stray starts and variable gaps.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       r = 5'd31;
        1:       r = 5'($urandom_range(26, 30));
        default: r = 5'($urandom_range(0, 25));
      endcase
      send(r);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 20)) @(posedge iCLK);
        send(5'($urandom));
      end
      if ($urandom_range(0, 1) == 0) begin
        wait_idle(400);
      end else begin
        repeat ($urandom_range(0, 3)) @(posedge iCLK);
      end
    end
    wait_idle(400);
    repeat (3) @(negedge iCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
